// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default).
// Counters start at the sync pulse. Sync and blanking outputs are registered
// from the next-state counter values, so they always match the coordinates
// presented in the same cycle.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       pix_tick,
   output logic       frame_start
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_START = H_SYNC + H_BP;
   localparam int V_START = V_SYNC + V_BP;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNCW = 10'(H_SYNC);
   localparam logic [9:0] V_SYNCW = 10'(V_SYNC);
   localparam logic [9:0] H_BEG   = 10'(H_START);
   localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE);
   localparam logic [9:0] V_BEG   = 10'(V_START);
   localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE);

   // CLK_DIV is 1..4, so two bits always hold the divider
   localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

   logic [1:0] div;
   logic       advance;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       hs_next;
   logic       vs_next;
   logic       von_next;

   assign advance = (div == DIV_LAST);

   // Raster position after the next advance edge, with line/frame wrap
   always_comb begin
      h_next = hcount + 10'd1;
      v_next = vcount;
      if (hcount == H_LAST) begin
         h_next = '0;
         v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end
   end

   // Outputs are decoded from the next position so they land with it
   assign hs_next  = (h_next >= H_SYNCW);
   assign vs_next  = (v_next >= V_SYNCW);
   assign von_next = (h_next >= H_BEG) && (h_next < H_END) &&
                     (v_next >= V_BEG) && (v_next < V_END);

   // Pixel-rate divider; with CLK_DIV=1 it stays at 0 and every edge advances
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else begin
         div <= advance ? 2'd0 : div + 2'd1;
      end
   end

   // Raster counters and registered timing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount      <= '0;
         vcount      <= '0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         video_on    <= 1'b0;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
      end else if (advance) begin
         hcount      <= h_next;
         vcount      <= v_next;
         hsync       <= hs_next;
         vsync       <= vs_next;
         video_on    <= von_next;
         pix_tick    <= 1'b1;
         frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
      end else begin
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance plus two shrunken
// rasters (CLK_DIV=3 and CLK_DIV=1) so full frames fit in a short run.
// A closed-form model from clocks-since-reset predicts every output each cycle.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   c = 0;          // rising edges since reset release
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= 0;
      else        c <= c + 1;
   end

   logic [9:0] d_h, d_v, s_h, s_v, o_h, o_v;
   logic d_hs, d_vs, d_von, d_pt, d_fs;
   logic s_hs, s_vs, s_von, s_pt, s_fs;
   logic o_hs, o_vs, o_von, o_pt, o_fs;

   vga_timing_gen u_dflt (
      .clk(clk), .rst_n(rst_n), .hcount(d_h), .vcount(d_v), .hsync(d_hs),
      .vsync(d_vs), .video_on(d_von), .pix_tick(d_pt), .frame_start(d_fs));

   vga_timing_gen #(.CLK_DIV(3), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
                    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1)) u_small (
      .clk(clk), .rst_n(rst_n), .hcount(s_h), .vcount(s_v), .hsync(s_hs),
      .vsync(s_vs), .video_on(s_von), .pix_tick(s_pt), .frame_start(s_fs));

   vga_timing_gen #(.CLK_DIV(1), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
                    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1)) u_div1 (
      .clk(clk), .rst_n(rst_n), .hcount(o_h), .vcount(o_v), .hsync(o_hs),
      .vsync(o_vs), .video_on(o_von), .pix_tick(o_pt), .frame_start(o_fs));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected {hcount, vcount, hsync, vsync, video_on, pix_tick, frame_start}
   function automatic logic [24:0] exp_vec(int cc, int d, int hs, int hb, int ha, int hf,
                                           int vs, int vb, int va, int vf);
      int ht, vt, p, h, v;
      logic von, pt;
      ht  = hs + hb + ha + hf;
      vt  = vs + vb + va + vf;
      p   = cc / d;
      h   = p % ht;
      v   = (p / ht) % vt;
      von = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
      pt  = (cc > 0) && (cc % d == 0);
      return {10'(h), 10'(v), h >= hs, v >= vs, von, pt, pt && h == 0 && v == 0};
   endfunction

   // Per-cycle model comparison, video_on edge positions and pix_tick spacing
   logic prev_von = 1'b0;
   int   last_tick = -1;
   always @(negedge clk) begin
      chk("dflt_vec", {7'b0, d_h, d_v, d_hs, d_vs, d_von, d_pt, d_fs},
          {7'b0, exp_vec(c, 2, 96, 48, 640, 16, 2, 33, 480, 10)});
      chk("small_vec", {7'b0, s_h, s_v, s_hs, s_vs, s_von, s_pt, s_fs},
          {7'b0, exp_vec(c, 3, 4, 3, 8, 2, 2, 2, 5, 1)});
      chk("div1_vec", {7'b0, o_h, o_v, o_hs, o_vs, o_von, o_pt, o_fs},
          {7'b0, exp_vec(c, 1, 4, 3, 8, 2, 2, 2, 5, 1)});
      if (!rst_n) begin
         prev_von  = 1'b0;
         last_tick = -1;
      end else begin
         if (s_von && !prev_von) chk("von_rise_h", 32'(s_h), 32'd7);
         if (!s_von && prev_von) chk("von_fall_h", 32'(s_h), 32'd15);
         if (s_von) chk("von_v_range", 32'(s_v >= 10'd4 && s_v <= 10'd8), 32'd1);
         prev_von = s_von;
         if (s_pt) begin
            if (last_tick >= 0) chk("tick_gap", 32'(c - last_tick), 32'd3);
            last_tick = c;
         end
      end
   end

   int cnt;
   int n;

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_h",   32'(d_h), 32'd0);
      chk("rst_v",   32'(d_v), 32'd0);
      chk("rst_hs",  32'(d_hs), 32'd0);
      chk("rst_vs",  32'(d_vs), 32'd0);
      chk("rst_von", 32'(d_von), 32'd0);
      chk("rst_pt",  32'(d_pt), 32'd0);
      chk("rst_fs",  32'(d_fs), 32'd0);
      rst_n = 1'b1;

      // first edges after release
      @(posedge clk); #1;
      chk("e1_h",      32'(d_h), 32'd0);
      chk("e1_pt",     32'(d_pt), 32'd0);
      chk("e1_div1_h", 32'(o_h), 32'd1);
      chk("e1_div1_pt",32'(o_pt), 32'd1);
      chk("e1_fs",     32'(o_fs), 32'd0);
      @(posedge clk); #1;
      chk("e2_h",  32'(d_h), 32'd1);
      chk("e2_pt", 32'(d_pt), 32'd1);

      // any 1600-clk window holds exactly 192 clks of hsync low
      cnt = 0;
      repeat (1600) begin
         if (!d_hs) cnt++;
         @(posedge clk); #1;
      end
      chk("hs_low_clks", 32'(cnt), 32'd192);

      // frame period and vsync width on the small raster: 17*10*3 and 2*17*3
      n = 0;
      while (!s_fs && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("fs_seen", 32'(s_fs), 32'd1);
      chk("fs_at_origin", {s_h, s_v}, 32'd0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!s_fs && n < 2000);
      chk("frame_period", 32'(n), 32'd510);
      cnt = 0;
      repeat (510) begin
         if (!s_vs) cnt++;
         @(posedge clk); #1;
      end
      chk("vs_low_clks", 32'(cnt), 32'd102);

      // CLK_DIV=1: pix_tick never drops
      cnt = 0;
      repeat (100) begin
         if (o_pt) cnt++;
         @(posedge clk); #1;
      end
      chk("div1_tick_high", 32'(cnt), 32'd100);

      // asynchronous reset in the middle of a visible line
      n = 0;
      while (!(s_v == 10'd5 && s_h == 10'd9) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pre_rst_pos", {s_h, s_v}, {22'd0, 10'd9} << 10 | 32'd5);
      chk("pre_rst_von", 32'(s_von), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_h",   32'(s_h), 32'd0);
      chk("async_v",   32'(s_v), 32'd0);
      chk("async_hs",  32'(s_hs), 32'd0);
      chk("async_vs",  32'(s_vs), 32'd0);
      chk("async_von", 32'(s_von), 32'd0);
      chk("async_pt",  32'(o_pt), 32'd0);
      chk("async_dh",  32'(d_h), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("re1_small_h", 32'(s_h), 32'd0);
      @(posedge clk); #1;
      chk("re2_h",  32'(d_h), 32'd1);
      chk("re2_pt", 32'(d_pt), 32'd1);
      chk("re2_small_pt", 32'(s_pt), 32'd0);
      @(posedge clk); #1;
      chk("re3_small_h",  32'(s_h), 32'd1);
      chk("re3_small_pt", 32'(s_pt), 32'd1);

      // let the per-cycle model cover a couple more small frames
      repeat (1200) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
